strobe_arbiter: RTL

- Shares one strobe-based clock-crossing channel between NREQ requesters in the source clock domain.
- Round-robin arbitration, one word per grant. Captures the winner's data and tags it with the requester ID.
- Issues a single-cycle strobe to the crossing channel.
- Spaces consecutive strobes far enough apart that the destination-side synchroniser sees every flag toggle.

---
 rtl/strobe_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/strobe_arbiter.sv
// rtl/strobe_arbiter.sv - round-robin arbiter feeding one strobe-based clock-crossing channel
// Optional macro STROBE_ACK_EN adds toggle-ack flow control from the destination domain.
module strobe_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2,
  parameter int GAP   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  xfer_strobe,
  output logic [WIDTH+IDW-1:0]  xfer_data,
  output logic                  busy,
  input  logic                  ack_in
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam int            CW        = $clog2(GAP + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(GAP - 2);

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  hold_cnt;
  logic           any_valid;
  logic [IDW-1:0] winner;
  logic           ack_ok;

  // First valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_l;
    idx       = 0;
    idx_l     = '0;
    any_valid = 1'b0;
    winner    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NREQ;
      idx_l = IDW'(idx);
      if (!any_valid && req_valid[idx_l]) begin
        any_valid = 1'b1;
        winner    = idx_l;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && state == S_IDLE && any_valid) req_ready[winner] = 1'b1;
  end

`ifdef STROBE_ACK_EN
  logic ack_sync1;
  logic ack_sync2;
  logic exp_par;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync1 <= 1'b0;
      ack_sync2 <= 1'b0;
      exp_par   <= 1'b0;
    end else begin
      ack_sync1 <= ack_in;
      ack_sync2 <= ack_sync1;
      if (state == S_ISSUE) exp_par <= ~exp_par;
    end
  end

  assign ack_ok = (ack_sync2 == exp_par);
  localparam bit SKIP_HOLD = 1'b0;
`else
  logic unused_ack;
  assign unused_ack = ack_in;
  assign ack_ok     = 1'b1;
  // With GAP==2 the ISSUE cycle alone provides the full spacing.
  localparam bit SKIP_HOLD = (GAP == 2);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      xfer_strobe <= 1'b0;
      xfer_data   <= '0;
      hold_cnt    <= '0;
    end else begin
      xfer_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            xfer_data   <= {winner, req_data[int'(winner)*WIDTH +: WIDTH]};
            rr_ptr      <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            xfer_strobe <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          hold_cnt <= HOLD_LOAD;
          state    <= SKIP_HOLD ? S_IDLE : S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          // Leaving on the count-of-one cycle keeps handshake spacing at exactly GAP.
          if (hold_cnt <= CW'(1) && ack_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
